// File: rtl/occ_pkg.sv
// Shared definitions for the Occ table writer and reader: base codes and builder FSM states.
package occ_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef logic [1:0] occState_t;

  localparam occState_t ST_IDLE   = 2'd0;
  localparam occState_t ST_LOAD   = 2'd1;
  localparam occState_t ST_FINISH = 2'd2;

endpackage

// File: rtl/occ_counter.sv
// Running per-base occurrence counter with synchronous clear and count enable.
module occ_counter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/occ_table_builder.sv
// Streams BWT bases into the four Occ SRAM banks and derives the C-array once the stream ends.
module occ_table_builder
  import occ_pkg::*;
#(
  parameter int unsigned REF_NUM    = 1024,
  parameter int unsigned REF_LENGTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bwt_valid,
  input  logic [1:0]            bwt_base,
  output logic                  bwt_ready,
  output logic                  wEn,
  output logic [REF_LENGTH-1:0] wAddr,
  output logic [REF_LENGTH-1:0] wData0,
  output logic [REF_LENGTH-1:0] wData1,
  output logic [REF_LENGTH-1:0] wData2,
  output logic [REF_LENGTH-1:0] wData3,
  output logic                  busy,
  output logic                  done,
  output logic [REF_LENGTH:0]   c_A,
  output logic [REF_LENGTH:0]   c_C,
  output logic [REF_LENGTH:0]   c_G,
  output logic [REF_LENGTH:0]   c_T
);

  localparam int unsigned CW = REF_LENGTH + 1;
  localparam logic [REF_LENGTH-1:0] LAST_IDX = REF_LENGTH'(REF_NUM - 1);

  occState_t             state, stateNext;
  logic [REF_LENGTH-1:0] index;
  logic                  accept, startOk, lastAccept;
  logic [3:0]            cntEn;
  logic [CW-1:0]         cnt [4];
  logic                  unusedCntTop;

  assign startOk    = (state == ST_IDLE) && start;
  assign accept     = (state == ST_LOAD) && bwt_valid && bwt_ready;
  assign lastAccept = accept && (index == LAST_IDX);

  // The T total never feeds the C-array; only its low bits reach the bank.
  assign unusedCntTop = cnt[3][REF_LENGTH];

  always_comb begin
    cntEn = '0;
    if (accept) begin
      unique case (bwt_base)
        BASE_A: cntEn[0] = 1'b1;
        BASE_C: cntEn[1] = 1'b1;
        BASE_G: cntEn[2] = 1'b1;
        BASE_T: cntEn[3] = 1'b1;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : gen_cnt
    occ_counter #(
      .WIDTH(CW)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (startOk),
      .en   (cntEn[k]),
      .count(cnt[k])
    );
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:   if (start) stateNext = ST_LOAD;
      ST_LOAD:   if (lastAccept) stateNext = ST_FINISH;
      ST_FINISH: stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      index     <= '0;
      bwt_ready <= 1'b0;
      wEn       <= 1'b0;
      wAddr     <= '0;
      wData0    <= '0;
      wData1    <= '0;
      wData2    <= '0;
      wData3    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      c_A       <= '0;
      c_C       <= '0;
      c_G       <= '0;
      c_T       <= '0;
    end else begin
      state <= stateNext;
      wEn   <= accept;
      done  <= (state == ST_FINISH);
      if (startOk) begin
        index     <= '0;
        busy      <= 1'b1;
        bwt_ready <= 1'b1;
      end
      // Write carries the pre-increment counts: Occ(c,i) excludes BWT[i] itself.
      if (accept) begin
        wAddr  <= index;
        wData0 <= cnt[0][REF_LENGTH-1:0];
        wData1 <= cnt[1][REF_LENGTH-1:0];
        wData2 <= cnt[2][REF_LENGTH-1:0];
        wData3 <= cnt[3][REF_LENGTH-1:0];
        index  <= index + REF_LENGTH'(1);
      end
      if (lastAccept) begin
        bwt_ready <= 1'b0;
      end
      if (state == ST_FINISH) begin
        busy <= 1'b0;
        c_A  <= '0;
        c_C  <= cnt[0];
        c_G  <= cnt[0] + cnt[1];
        c_T  <= cnt[0] + cnt[1] + cnt[2];
      end
    end
  end

endmodule

// File: tb/tb_occ_table_builder.sv
// Bench for occ_table_builder: small-table builds with gaps, restarts and reset, plus a full-size all-A build.
module tb_occ_table_builder;

  localparam int N8  = 8;
  localparam int L8  = 3;
  localparam int N1K = 1024;
  localparam int L1K = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start, bwtValid;
  logic [1:0] bwtBase;

  logic          ready8, wEn8, busy8, done8;
  logic [L8-1:0] wAddr8, wd80, wd81, wd82, wd83;
  logic [L8:0]   cA8, cC8, cG8, cT8;

  logic           start1k, valid1k;
  logic [1:0]     base1k;
  logic           ready1k, wEn1k, busy1k, done1k;
  logic [L1K-1:0] wAddr1k, wd1k0, wd1k1, wd1k2, wd1k3;
  logic [L1K:0]   cA1k, cC1k, cG1k, cT1k;

  occ_table_builder #(.REF_NUM(N8), .REF_LENGTH(L8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .bwt_valid(bwtValid), .bwt_base(bwtBase),
    .bwt_ready(ready8), .wEn(wEn8), .wAddr(wAddr8),
    .wData0(wd80), .wData1(wd81), .wData2(wd82), .wData3(wd83),
    .busy(busy8), .done(done8), .c_A(cA8), .c_C(cC8), .c_G(cG8), .c_T(cT8)
  );

  occ_table_builder #(.REF_NUM(N1K), .REF_LENGTH(L1K)) dut1k (
    .clk(clk), .rst_n(rst_n), .start(start1k), .bwt_valid(valid1k), .bwt_base(base1k),
    .bwt_ready(ready1k), .wEn(wEn1k), .wAddr(wAddr1k),
    .wData0(wd1k0), .wData1(wd1k1), .wData2(wd1k2), .wData3(wd1k3),
    .busy(busy1k), .done(done1k), .c_A(cA1k), .c_C(cC1k), .c_G(cG1k), .c_T(cT1k)
  );

  int checks = 0;
  int passes = 0;
  logic [1:0] stream [N8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) begin
      passes = passes + 1;
    end else begin
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Reference: Occ counts are a running tally of bases already consumed from the stream.
  task automatic runBuild8(input int gapMode, input bit midStart);
    int idx, cyc;
    int occ [4];
    bit acc;
    occ = '{0, 0, 0, 0};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy8, 1);
    chk("ready_after_start", ready8, 1);
    idx = 0;
    cyc = 0;
    while (idx < N8 && cyc < 200) begin
      case (gapMode)
        0:       bwtValid = 1'b1;
        1:       bwtValid = (cyc % 2 == 0);
        default: bwtValid = 1'($urandom_range(0, 1));
      endcase
      bwtBase = bwtValid ? stream[idx] : 2'($urandom_range(0, 3));
      start = midStart && (cyc == 4);
      acc = bwtValid;
      chk("ready_load", ready8, 1);
      chk("busy_load", busy8, 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("wEn", wEn8, acc);
      if (acc) begin
        chk("wAddr", wAddr8, idx);
        chk("wData0", wd80, occ[0]);
        chk("wData1", wd81, occ[1]);
        chk("wData2", wd82, occ[2]);
        chk("wData3", wd83, occ[3]);
        occ[stream[idx]] = occ[stream[idx]] + 1;
        idx = idx + 1;
      end
      cyc = cyc + 1;
      @(negedge clk);
    end
    chk("load_within_bound", cyc < 200, 1);
    bwtValid = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", done8, 1);
    chk("busy_dropped", busy8, 0);
    chk("wEn_after_last", wEn8, 0);
    chk("ready_after_last", ready8, 0);
    chk("c_A", cA8, 0);
    chk("c_C", cC8, occ[0]);
    chk("c_G", cG8, occ[0] + occ[1]);
    chk("c_T", cT8, occ[0] + occ[1] + occ[2]);
    @(posedge clk); #1;
    chk("done_one_cycle", done8, 0);
    chk("c_T_holds", cT8, occ[0] + occ[1] + occ[2]);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bwtValid = 1'b0;
    bwtBase = 2'b00;
    start1k = 1'b0;
    valid1k = 1'b0;
    base1k = 2'b00;
    #12;
    chk("rst_ready", ready8, 0);
    chk("rst_wEn", wEn8, 0);
    chk("rst_wAddr", wAddr8, 0);
    chk("rst_wData", {wd80, wd81, wd82, wd83}, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_c", {cA8, cC8, cG8, cT8}, 0);
    chk("rst_busy1k", busy1k, 0);
    @(negedge clk); rst_n = 1'b1;

    // ACGTTGCA, continuous then every-other-cycle valid, then with a stray start.
    stream = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    runBuild8(0, 1'b0);
    chk("acgt_c_C", cC8, 2);
    chk("acgt_c_G", cG8, 4);
    chk("acgt_c_T", cT8, 6);
    runBuild8(1, 1'b0);
    runBuild8(0, 1'b1);

    // Reset after three accepts.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    bwtValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bwtBase = stream[i];
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_wEn", wEn8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_ready", ready8, 0);
    chk("midrst_wAddr", wAddr8, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_no_write", wEn8, 0);
    end
    @(negedge clk); bwtValid = 1'b0;
    runBuild8(0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N8; i++) stream[i] = 2'($urandom_range(0, 3));
      runBuild8(2, (r % 2) == 1);
    end

    // Full-size all-A build.
    @(negedge clk); start1k = 1'b1;
    @(negedge clk); start1k = 1'b0; valid1k = 1'b1;
    for (int i = 0; i < N1K; i++) begin
      @(posedge clk); #1;
      if (i % 128 == 0 || i == N1K - 1) begin
        chk("big_wEn", wEn1k, 1);
        chk("big_wAddr", wAddr1k, i);
        chk("big_wData0", wd1k0, i);
        chk("big_wDataCGT", {wd1k1, wd1k2, wd1k3}, 0);
      end
    end
    valid1k = 1'b0;
    @(posedge clk); #1;
    chk("big_done", done1k, 1);
    chk("big_c_A", cA1k, 0);
    chk("big_c_C", cC1k, 1024);
    chk("big_c_G", cG1k, 1024);
    chk("big_c_T", cT1k, 1024);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/occ_table_builder.md
# occ_table_builder

Builds the four occurrence (Occ) tables of the FM-index from a serial stream of BWT bases and writes them into the OCC A/C/G/T SRAM banks. It is the write-side counterpart of the two-port Occ lookup used during backward search. It also produces the C-array, the count of bases lexicographically smaller than each base, for the search controller. It runs once per reference load, before alignment starts.

## Interface
Parameters:
- REF_NUM, 1024, number of Occ entries per table (BWT length consumed)
- REF_LENGTH, 10, address and Occ data width; REF_NUM ≤ 2^REF_LENGTH

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin a build (honoured only in IDLE)
- bwt_valid  in  1  bwt_base valid this cycle
- bwt_base  in  2  base code: 00=A, 01=C, 10=G, 11=T
- bwt_ready  out  1  builder accepts a base this cycle
- wEn  out  1  write strobe, common to all four banks
- wAddr  out  REF_LENGTH  write address (BWT index i)
- wData0..wData3  out  REF_LENGTH each  Occ(A/C/G/T, i) for the A/C/G/T banks
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final write
- c_A, c_C, c_G, c_T  out  REF_LENGTH+1 each  C-array, valid from done until next start

## Operation
- Occ(c,i) = number of base c in BWT[0..i-1]; Occ(c,0)=0. Max value is REF_NUM-1, which fits REF_LENGTH bits.
- Four running counters cntA..cntT, each REF_LENGTH+1 bits wide.
- FSM states: IDLE, LOAD, FINISH.
  - IDLE: bwt_ready=0. On start, clear counters, set index=0, go to LOAD.
  - LOAD: bwt_ready=1. On bwt_valid&bwt_ready (accept), register a write with wAddr=index and wDataN=cntN (pre-increment). Then increment the counter selected by bwt_base and increment index. If the accept is at index REF_NUM-1, go to FINISH.
  - FINISH: latch c_A=0, c_C=cntA, c_G=cntA+cntC, c_T=cntA+cntC+cntG. Pulse done and return to IDLE.
- No accept cycle means no write. bwt_valid gaps stall the build indefinitely.
- start while busy is ignored. start in the same cycle as done's return to IDLE is not possible; start is sampled only in IDLE.
- Final totals sum to REF_NUM. The sentinel is excluded from the stream and handled by the search controller.

## Timing
- Reset values: bwt_ready=0, wEn=0, wAddr=0, wData0..3=0, busy=0, done=0, c_*=0, state=IDLE, counters=0.
- All outputs are registered.
- start accepted at cycle t: busy=1 and bwt_ready=1 at t+1.
- Accept at cycle t: wEn=1 with the matching wAddr/wData at t+1, one cycle wide. The SRAM captures the write on that edge.
- With continuous valid, the build takes REF_NUM+2 cycles from start to done.
- done and valid c_* appear one cycle after the last wEn. busy drops in the same cycle done is asserted.
- Reset mid-LOAD: everything returns to reset values immediately and no further writes occur. The table contents are then undefined and a new start is required.

## Structure
- Shared package occ_pkg: base code constants BASE_A..BASE_T (shared with the Occ reader's select encoding) and the FSM state enum.
- One natural sub-module, occ_counter: a REF_LENGTH+1 counter with synchronous clear and enable, instantiated four times and enabled by the decoded bwt_base.
- The remainder is the FSM, the index register, the output registers and the C-array adder chain.

## Test plan
- Reset: hold rst_n=0 → all outputs 0, bwt_ready=0; start pulse → busy=1 and bwt_ready=1 next cycle.
- REF_NUM=8, stream ACGTTGCA continuous → writes to addr 0..7 with (A,C,G,T) = (0,0,0,0), (1,0,0,0), (1,1,0,0), (1,1,1,0), (1,1,1,1), (1,1,1,2), (1,1,2,2), (1,2,2,2); done → c_A=0, c_C=2, c_G=4, c_T=6.
- Same stream with bwt_valid deasserted every other cycle → identical writes, no wEn in gap cycles, done at cycle 2·8+1.
- start pulsed mid-LOAD → ignored, no index or counter change; build completes normally.
- rst_n asserted after 3 accepts → wEn=0 and busy=0 immediately, no further writes; a new start rebuilds from addr 0.
- Default REF_NUM=1024, all bases A → last write addr 1023 with wData0=1023; c_C=c_G=c_T=1024.
